line_fill_engine: RTL

//  Refill sequencer between word-serial main memory and the L1 instruction-cache write port.
//  On a miss it reads every word of the aligned line from main memory, one request per word,
//  and buffers the words. It then writes the full line into the cache in a single cycle.
//  It replaces the separate line-adapter/controller pair.

---
 rtl/line_fill_engine.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/line_fill_engine.sv
// Refill sequencer: reads one aligned cache line word-by-word from main memory, then writes it to L1 in one cycle.
// Latency: a fill accepted at edge k raises line_we/fill_done W*(L+1) edges later, where L is the memory valid delay.
// Backpressure: none queued; miss_req is ignored while busy, mm_valid is waited on in READ, clr aborts any fill.
module line_fill_engine #(
    parameter int ADDR_SIZE      = 14,
    parameter int WORD_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                                MEM_CLK,
    input  logic                                RST,
    input  logic                                clr,
    input  logic                                miss_req,
    input  logic [ADDR_SIZE-1:0]                miss_addr,
    output logic                                busy,
    output logic                                mm_re,
    output logic [ADDR_SIZE-1:0]                mm_addr,
    output logic                                mm_rst,
    input  logic                                mm_valid,
    input  logic [WORD_SIZE-1:0]                mm_data,
    output logic                                line_we,
    output logic [ADDR_SIZE-1:0]                line_addr,
    output logic [WORDS_PER_LINE*WORD_SIZE-1:0] line_data,
    output logic                                fill_done
);

    localparam int CW = $clog2(WORDS_PER_LINE);
    localparam int LW = WORDS_PER_LINE * WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        GAP   = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] base_q, base_d;
    logic [LW-1:0]        line_buf_q;
    logic [ADDR_SIZE-1:0] line_addr_q;
    logic [LW-1:0]        line_data_q;

    // Capture a word only when it answers our own READ request; clr wins over a coincident valid.
    logic buf_we;
    // The last GAP of a fill publishes the completed line; the published copy survives later aborts and refills.
    logic line_load;

    // State register, word counter and latched line base.
    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Next-state logic and registered-state output decodes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        busy      = (state_q != IDLE);
        mm_re     = 1'b0;
        mm_addr   = '0;
        mm_rst    = clr;
        line_we   = 1'b0;
        fill_done = 1'b0;
        buf_we    = 1'b0;
        line_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    base_d  = miss_addr & ~ADDR_SIZE'(WORDS_PER_LINE - 1);
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                mm_re   = 1'b1;
                // Base low bits are zero, so OR-ing the counter never carries out of the line.
                mm_addr = base_q | ADDR_SIZE'(cnt_q);
                if (mm_valid) begin
                    buf_we  = !clr;
                    state_d = GAP;
                end
            end
            GAP: begin
                mm_rst = 1'b1;
                if (cnt_q == CW'(WORDS_PER_LINE - 1)) begin
                    line_load = !clr;
                    state_d   = WRITE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = READ;
                end
            end
            WRITE: begin
                line_we   = 1'b1;
                fill_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Word buffer: each returning word lands in the slot selected by the word counter.
    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) begin
            line_buf_q <= '0;
        end else begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                if (buf_we && (cnt_q == CW'(i))) begin
                    line_buf_q[i*WORD_SIZE +: WORD_SIZE] <= mm_data;
                end
            end
        end
    end

    // Published line: loaded on entry to WRITE and held until the next completed fill.
    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) begin
            line_addr_q <= '0;
            line_data_q <= '0;
        end else if (line_load) begin
            line_addr_q <= base_q;
            line_data_q <= line_buf_q;
        end
    end

    assign line_addr = line_addr_q;
    assign line_data = line_data_q;

endmodule
